// File: rtl/obf_pkg.sv
// Shared defaults, count type and timer-width helper for the AND/XOR pair monitor.
package obf_pkg;

  localparam int DEB_CYC_DEF = 4;
  localparam int WIN_CYC_DEF = 64;
  localparam int CNT_W_DEF   = 8;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

  // Bits needed for a timer that counts 0..n-1 (never narrower than one bit).
  function automatic int timer_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/obf_sync_debounce.sv
// Two-flop synchroniser plus debounce filter for one asynchronous level input.
// rise_o is combinational and marks the edge on which stable_o goes 0->1.
module obf_sync_debounce
  import obf_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic stable_o,
  output logic rise_o
);

  localparam int            DW       = timer_w(DEB_CYC);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);

  logic [1:0]    sync_reg;
  logic          stable_reg;
  logic [DW-1:0] deb_cnt_reg;
  logic          sync_lvl;
  logic          accept;

  assign sync_lvl = sync_reg[1];
  // A new level is taken once it has differed from the settled level for DEB_CYC cycles.
  assign accept   = (sync_lvl != stable_reg) && (deb_cnt_reg == DEB_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_reg    <= '0;
      stable_reg  <= 1'b0;
      deb_cnt_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[0], d_i};
      if ((sync_lvl == stable_reg) || accept) begin
        deb_cnt_reg <= '0;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + 1'b1;
      end
      if (accept) begin
        stable_reg <= sync_lvl;
      end
    end
  end

  assign stable_o = stable_reg;
  assign rise_o   = accept & sync_lvl;

endmodule

// File: rtl/obf_pair_monitor.sv
// Counts debounced rising edges of the upstream AND and XOR outputs per fixed window
// and presents each window's counts to a reader over a valid/ready handshake.
module obf_pair_monitor
  import obf_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEF,
  parameter int WIN_CYC = WIN_CYC_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             and_i,
  input  logic             xor_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [CNT_W-1:0] and_cnt_o,
  output logic [CNT_W-1:0] xor_cnt_o,
  output logic             ovr_o
);

  localparam int               WW       = timer_w(WIN_CYC);
  localparam logic [WW-1:0]    WIN_LAST = WW'(WIN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]       pin_lvl;
  logic [1:0]       rise;
  logic [1:0]       stable_lvl;
  logic [CNT_W-1:0] edge_cnt_next [2];

  logic [WW-1:0]    win_cnt_reg;
  logic             win_end;
  logic             valid_reg;
  logic             ovr_reg;
  logic [CNT_W-1:0] and_cnt_reg;
  logic [CNT_W-1:0] xor_cnt_reg;

  assign pin_lvl = {xor_i, and_i};
  assign win_end = (win_cnt_reg == WIN_LAST);

  // Channel 0 is the AND output, channel 1 the XOR output.
  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic [CNT_W-1:0] edge_cnt_reg;

    obf_sync_debounce #(
      .DEB_CYC (DEB_CYC)
    ) u_deb (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .d_i      (pin_lvl[gi]),
      .stable_o (stable_lvl[gi]),
      .rise_o   (rise[gi])
    );

    // A rise is only ever reported from a low settled level; the count saturates.
    assign edge_cnt_next[gi] =
      (rise[gi] && !stable_lvl[gi] && (edge_cnt_reg != CNT_MAX)) ? edge_cnt_reg + 1'b1
                                                                 : edge_cnt_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        edge_cnt_reg <= '0;
      end else begin
        edge_cnt_reg <= win_end ? '0 : edge_cnt_next[gi];
      end
    end
  end

  // Window end always loads a fresh snapshot; an unaccepted one being replaced is an overrun.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_cnt_reg <= '0;
      valid_reg   <= 1'b0;
      ovr_reg     <= 1'b0;
      and_cnt_reg <= '0;
      xor_cnt_reg <= '0;
    end else begin
      win_cnt_reg <= win_end ? '0 : win_cnt_reg + 1'b1;
      if (win_end) begin
        and_cnt_reg <= edge_cnt_next[0];
        xor_cnt_reg <= edge_cnt_next[1];
        valid_reg   <= 1'b1;
        if (valid_reg && !ready_i) begin
          ovr_reg <= 1'b1;
        end
      end else if (valid_reg && ready_i) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign valid_o   = valid_reg;
  assign ovr_o     = ovr_reg;
  assign and_cnt_o = and_cnt_reg;
  assign xor_cnt_o = xor_cnt_reg;

endmodule

// File: tb/tb_obf_pair_monitor.sv
// Directed bench for obf_pair_monitor: an 8-bit and a 2-bit instance share stimulus and
// are compared every cycle against a pin-history model, plus literal spot checks.
module tb_obf_pair_monitor;

  localparam int DEB = 4;
  localparam int WIN = 64;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       and_in = 1'b0;
  logic       xor_in = 1'b0;
  logic       ready  = 1'b0;
  logic       valid8, ovr8, valid2, ovr2;
  logic [7:0] and8, xor8;
  logic [1:0] and2, xor2;

  always #5 clk = ~clk;

  obf_pair_monitor #(.DEB_CYC(DEB), .WIN_CYC(WIN), .CNT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .and_i(and_in), .xor_i(xor_in),
    .valid_o(valid8), .ready_i(ready), .and_cnt_o(and8), .xor_cnt_o(xor8), .ovr_o(ovr8)
  );

  obf_pair_monitor #(.DEB_CYC(DEB), .WIN_CYC(WIN), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .and_i(and_in), .xor_i(xor_in),
    .valid_o(valid2), .ready_i(ready), .and_cnt_o(and2), .xor_cnt_o(xor2), .ovr_o(ovr2)
  );

  int checks = 0;
  int errors = 0;

  // Model: pin level seen before each edge since reset release, settled levels,
  // unbounded edge counts (saturated only when reported), and the handshake state.
  bit and_hist [0:2047];
  bit xor_hist [0:2047];
  bit m_and_st, m_xor_st, m_valid, m_ovr;
  int m_cyc, m_and_cnt, m_xor_cnt, m_and_snap, m_xor_snap;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d after reset)", name, act, exp, m_cyc);
    end
  endfunction

  function automatic int sat(input int v, input int w);
    int top;
    top = (1 << w) - 1;
    return (v > top) ? top : v;
  endfunction

  function automatic void model_reset();
    m_cyc = 0; m_and_st = 0; m_xor_st = 0; m_valid = 0; m_ovr = 0;
    m_and_cnt = 0; m_xor_cnt = 0; m_and_snap = 0; m_xor_snap = 0;
  endfunction

  // The settled level flips when the last DEB synchronised samples (pins two edges
  // earlier; zero before reset release) all disagree with it.
  function automatic bit flips(input int ch, input bit st);
    int k;
    bit v;
    for (int j = 0; j < DEB; j++) begin
      k = m_cyc - 2 - j;
      if (k >= 1) v = (ch == 0) ? and_hist[k] : xor_hist[k];
      else        v = 1'b0;
      if (v == st) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_edge(input bit r, input bit a, input bit x, input bit rdy);
    if (!r) begin
      model_reset();
      return;
    end
    m_cyc++;
    and_hist[m_cyc] = a;
    xor_hist[m_cyc] = x;
    if (flips(0, m_and_st)) begin
      if (!m_and_st) m_and_cnt++;
      m_and_st = !m_and_st;
    end
    if (flips(1, m_xor_st)) begin
      if (!m_xor_st) m_xor_cnt++;
      m_xor_st = !m_xor_st;
    end
    if (m_cyc % WIN == 0) begin
      if (m_valid && !rdy) m_ovr = 1;
      m_valid    = 1;
      m_and_snap = m_and_cnt;
      m_xor_snap = m_xor_cnt;
      m_and_cnt  = 0;
      m_xor_cnt  = 0;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endfunction

  function automatic void compare_all();
    check("valid",      valid8, int'(m_valid));
    check("valid_w2",   valid2, int'(m_valid));
    check("ovr",        ovr8,   int'(m_ovr));
    check("ovr_w2",     ovr2,   int'(m_ovr));
    check("and_cnt",    and8,   sat(m_and_snap, 8));
    check("xor_cnt",    xor8,   sat(m_xor_snap, 8));
    check("and_cnt_w2", and2,   sat(m_and_snap, 2));
    check("xor_cnt_w2", xor2,   sat(m_xor_snap, 2));
  endfunction

  task automatic tick();
    bit r, a, x, rd;
    r = rst_n; a = and_in; x = xor_in; rd = ready;
    @(posedge clk);
    model_edge(r, a, x, rd);
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_and(input int hi, input int lo);
    and_in = 1'b1; run(hi);
    and_in = 1'b0; run(lo);
  endtask

  task automatic pulse_xor(input int hi, input int lo);
    xor_in = 1'b1; run(hi);
    xor_in = 1'b0; run(lo);
  endtask

  task automatic accept();
    ready = 1'b1; tick();
    ready = 1'b0;
  endtask

  initial begin
    model_reset();
    run(3);
    check("reset_valid", valid8, 0);
    check("reset_and",   and8,   0);
    rst_n = 1'b1;

    // Idle window: snapshot appears on the 64th edge after release.
    run(63);
    check("idle_valid_early", valid8, 0);
    run(1);
    check("idle_valid", valid8, 1);
    check("idle_and",   and8,   0);
    check("idle_xor",   xor8,   0);
    check("idle_ovr",   ovr8,   0);
    accept();
    check("idle_accept_valid", valid8, 0);

    // Three clean AND pulses; settled level rises 6 edges after the pin.
    and_in = 1'b1;
    run(5);
    check("and_stable_t5", dut.stable_lvl[0], 0);
    run(1);
    check("and_stable_t6", dut.stable_lvl[0], 1);
    run(2);
    and_in = 1'b0; run(8);
    pulse_and(8, 8);
    pulse_and(8, 8);
    run(15);
    check("three_pulse_valid", valid8, 1);
    check("three_pulse_and",   and8,   3);
    check("three_pulse_xor",   xor8,   0);
    accept();

    // XOR glitches of 1..3 cycles are rejected; a 4-cycle pulse counts once.
    pulse_xor(1, 6);
    pulse_xor(2, 6);
    pulse_xor(3, 6);
    pulse_xor(4, 6);
    run(29);
    check("glitch_xor", xor8, 1);
    check("glitch_and", and8, 0);
    accept();

    // Six AND pulses: 2-bit instance saturates at 3. Left unaccepted.
    for (int p = 0; p < 6; p++) pulse_and(5, 5);
    run(3);
    check("six_and_w8", and8, 6);
    check("six_and_w2", and2, 3);

    // Ready only on the window-end edge: new snapshot, valid held, no overrun.
    pulse_and(5, 5);
    run(53);
    ready = 1'b1; tick(); ready = 1'b0;
    check("coincide_valid", valid8, 1);
    check("coincide_and_w2", and2, 1);
    check("coincide_ovr",   ovr8,   0);

    // Not accepted across the next window end: overwrite sets the sticky overrun.
    pulse_xor(5, 5);
    pulse_xor(5, 5);
    run(44);
    check("ovr_set",     ovr8, 1);
    check("ovr_new_xor", xor8, 2);
    check("ovr_new_and", and8, 0);
    accept();
    check("ovr_sticky", ovr8, 1);
    check("ovr_accept_valid", valid8, 0);

    // Reset mid-window after two counted edges discards everything.
    pulse_and(8, 8);
    pulse_and(8, 8);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_ovr", ovr8, 0);
    check("midrst_xor", xor8, 0);
    compare_all();
    run(2);
    rst_n = 1'b1;
    pulse_and(8, 8);
    run(48);
    check("post_rst_valid", valid8, 1);
    check("post_rst_and",   and8,   1);
    check("post_rst_xor",   xor8,   0);
    check("post_rst_ovr",   ovr8,   0);
    accept();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
